rmii_tx: RTL and testbench

Transmit-side RMII MAC framer, the counterpart to `rmii_rx`; it drives the board's `eth_txen`/`eth_tx` pins, which are currently tied off. It accepts a byte stream over a valid/ready handshake and serialises one frame per `tx_last`-terminated packet at 100 Mb/s, two bits per clock, LSB first. Each frame is sent as preamble, then SFD, then payload, then zero-padding up to the minimum length, then FCS, followed by a fixed inter-frame gap.

---
 rtl/eth_pkg.sv | 19 +
 rtl/eth_crc32_2b.sv | 17 +
 rtl/rmii_tx.sv | 170 +++++++++++++++++
 tb/tb_rmii_tx.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet constants and TX framer state encoding
package eth_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_DATA     = 3'd2,
      ST_PAD      = 3'd3,
      ST_FCS      = 3'd4,
      ST_IFG      = 3'd5
   } tx_state_e;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

endpackage

// File: rtl/eth_crc32_2b.sv
// rtl/eth_crc32_2b.sv - reflected CRC-32 next state for one dibit, bit [0] first
module eth_crc32_2b
   import eth_pkg::*;
(
   input  logic [31:0] crc,
   input  logic [1:0]  dibit,
   output logic [31:0] crc_next
);

   logic [31:0] crc_mid;

   always_comb begin
      crc_mid  = {1'b0, crc[31:1]} ^ ((crc[0] ^ dibit[0]) ? CRC_POLY : 32'h0);
      crc_next = {1'b0, crc_mid[31:1]} ^ ((crc_mid[0] ^ dibit[1]) ? CRC_POLY : 32'h0);
   end

endmodule

// File: rtl/rmii_tx.sv
// rtl/rmii_tx.sv - RMII transmit framer: preamble, SFD, payload, pad, FCS, IFG
module rmii_tx
   import eth_pkg::*;
#(
   parameter int MIN_FRAME = 60,
   parameter int IFG_BYTES = 12
) (
   input  logic       eth_clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       eth_txen,
   output logic [1:0] eth_tx,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int          IFG_CLKS = IFG_BYTES * 4;
   localparam int          IFG_W    = (IFG_CLKS > 2) ? $clog2(IFG_CLKS) : 1;
   localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);

   tx_state_e        state;
   logic [5:0]       sr;          // dibits of the byte on the wire not yet driven
   logic [1:0]       slot;
   logic [2:0]       pre_idx;
   logic [3:0]       fcs_idx;
   logic [IFG_W-1:0] ifg_cnt;
   logic [10:0]      byte_cnt;
   logic [10:0]      cnt_inc;
   logic             last;
   logic [31:0]      crc;
   logic [31:0]      crc_next;
   logic [7:0]       pre_next;
   logic             take;
   logic             starve;

   eth_crc32_2b u_crc (
      .crc      (crc),
      .dibit    (eth_tx),
      .crc_next (crc_next)
   );

   always_comb begin
      tx_ready = ((state == ST_PREAMBLE) && (pre_idx == 3'd7) && (slot == 2'd3)) ||
                 ((state == ST_DATA) && (slot == 2'd3) && !last);
      take     = tx_ready && tx_valid;
      starve   = tx_ready && !tx_valid;
      busy     = (state != ST_IDLE);
      pre_next = (pre_idx == 3'd6) ? SFD_BYTE : PREAMBLE_BYTE;
      cnt_inc  = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
   end

   // The CRC register absorbs whatever dibit is on the wire while in DATA or PAD.
   always_ff @(posedge eth_clk) begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (rst) begin
         state    <= ST_IDLE;
         eth_txen <= 1'b0;
         eth_tx   <= 2'b00;
         sr       <= 6'd0;
         slot     <= 2'd0;
         pre_idx  <= 3'd0;
         fcs_idx  <= 4'd0;
         ifg_cnt  <= '0;
         byte_cnt <= 11'd0;
         last     <= 1'b0;
         crc      <= CRC_INIT;
      end else begin
         case (state)
            ST_IDLE: begin
               if (tx_valid) begin
                  state    <= ST_PREAMBLE;
                  eth_txen <= 1'b1;
                  eth_tx   <= PREAMBLE_BYTE[1:0];
                  sr       <= PREAMBLE_BYTE[7:2];
                  slot     <= 2'd0;
                  pre_idx  <= 3'd0;
                  byte_cnt <= 11'd0;
               end
            end
            ST_PREAMBLE: begin
               if (take) begin
                  crc      <= CRC_INIT;
                  state    <= ST_DATA;
                  sr       <= tx_data[7:2];
                  eth_tx   <= tx_data[1:0];
                  last     <= tx_last;
                  slot     <= 2'd0;
                  byte_cnt <= cnt_inc;
               end else if (starve) begin
                  state    <= ST_IFG;
                  eth_txen <= 1'b0;
                  eth_tx   <= 2'b00;
                  tx_err   <= 1'b1;
                  ifg_cnt  <= '0;
               end else if (slot != 2'd3) begin
                  sr     <= {2'b00, sr[5:2]};
                  eth_tx <= sr[1:0];
                  slot   <= slot + 2'd1;
               end else begin
                  pre_idx <= pre_idx + 3'd1;
                  slot    <= 2'd0;
                  sr      <= pre_next[7:2];
                  eth_tx  <= pre_next[1:0];
               end
            end
            ST_DATA, ST_PAD: begin
               crc <= crc_next;
               if (take) begin
                  sr       <= tx_data[7:2];
                  eth_tx   <= tx_data[1:0];
                  last     <= tx_last;
                  slot     <= 2'd0;
                  byte_cnt <= cnt_inc;
               end else if (starve) begin
                  state    <= ST_IFG;
                  eth_txen <= 1'b0;
                  eth_tx   <= 2'b00;
                  tx_err   <= 1'b1;
                  ifg_cnt  <= '0;
               end else if (slot != 2'd3) begin
                  sr     <= {2'b00, sr[5:2]};
                  eth_tx <= sr[1:0];
                  slot   <= slot + 2'd1;
               end else if (byte_cnt < MIN_CNT) begin
                  state    <= ST_PAD;
                  sr       <= 6'd0;
                  eth_tx   <= 2'b00;
                  slot     <= 2'd0;
                  byte_cnt <= cnt_inc;
               end else begin
                  state   <= ST_FCS;
                  eth_tx  <= ~crc_next[1:0];
                  fcs_idx <= 4'd0;
               end
            end
            ST_FCS: begin
               if (fcs_idx == 4'd15) begin
                  state    <= ST_IFG;
                  eth_txen <= 1'b0;
                  eth_tx   <= 2'b00;
                  ifg_cnt  <= '0;
               end else begin
                  eth_tx  <= ~crc[3:2];
                  crc     <= {2'b00, crc[31:2]};
                  fcs_idx <= fcs_idx + 4'd1;
                  tx_done <= (fcs_idx == 4'd14);
               end
            end
            ST_IFG: begin
               if (ifg_cnt == IFG_W'(IFG_CLKS - 1)) begin
                  state <= ST_IDLE;
               end else begin
                  ifg_cnt <= ifg_cnt + IFG_W'(1);
               end
            end
            default: begin
               state    <= ST_IDLE;
               eth_txen <= 1'b0;
               eth_tx   <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rmii_tx.sv
// tb/tb_rmii_tx.sv - directed self-checking bench for rmii_tx
module tb_rmii_tx;

   typedef logic [7:0] byte_q_t[$];
   typedef logic [1:0] dib_q_t[$];

   logic       eth_clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_last = 1'b0;
   logic       tx_ready;
   logic       eth_txen;
   logic [1:0] eth_tx;
   logic       busy;
   logic       tx_done;
   logic       tx_err;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   dib_q_t cur_dibs;
   dib_q_t last_dibs;
   int     cur_len = 0;
   int     burst_cnt = 0;
   int     starts[$];
   int     ends[$];
   int     lens[$];
   int     done_cnt = 0;
   int     err_cnt = 0;
   int     err_cyc = 0;
   int     ready_bad = 0;
   int     idle_bad = 0;

   rmii_tx #(.MIN_FRAME(60), .IFG_BYTES(12)) dut (
      .eth_clk  (eth_clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_last  (tx_last),
      .tx_ready (tx_ready),
      .eth_txen (eth_txen),
      .eth_tx   (eth_tx),
      .busy     (busy),
      .tx_done  (tx_done),
      .tx_err   (tx_err)
   );

   always #10 eth_clk = ~eth_clk;

   always @(posedge eth_clk) cyc++;

   // Wire monitor: collects each TX_EN burst and watches tx_ready placement.
   always @(negedge eth_clk) begin
      if (tx_done) done_cnt++;
      if (tx_err) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (tx_ready && !(eth_txen && (cur_len % 4 == 3))) ready_bad++;
      if (!eth_txen && eth_tx !== 2'b00) idle_bad++;
      if (eth_txen) begin
         if (cur_len == 0) starts.push_back(cyc);
         cur_dibs.push_back(eth_tx);
         cur_len++;
      end else if (cur_len != 0) begin
         ends.push_back(cyc - 1);
         lens.push_back(cur_len);
         last_dibs = cur_dibs;
         cur_dibs.delete();
         cur_len = 0;
         burst_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit (tests=%0d failed=%0d)", tests, fails);
      $fatal(1);
   end

   function automatic logic [31:0] crc_reg(input byte_q_t b);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (b[i]) begin
         c = c ^ {24'h0, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   function automatic void build_exp(input byte_q_t p, output dib_q_t d);
      byte_q_t     f;
      byte_q_t     pl;
      logic [31:0] fcs;
      logic [7:0]  b;
      f = {};
      for (int i = 0; i < 7; i++) f.push_back(8'h55);
      f.push_back(8'hD5);
      pl = p;
      while (pl.size() < 60) pl.push_back(8'h00);
      foreach (pl[i]) f.push_back(pl[i]);
      fcs = ~crc_reg(pl);
      for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
      d = {};
      foreach (f[i]) begin
         b = f[i];
         for (int k = 0; k < 4; k++) d.push_back(b[2*k +: 2]);
      end
   endfunction

   function automatic void dibs_to_bytes(input dib_q_t d, output byte_q_t b);
      b = {};
      for (int i = 0; i < d.size() / 4; i++) b.push_back({d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]});
   endfunction

   function automatic int count_diff(input dib_q_t a, input dib_q_t e);
      int n;
      n = (a.size() != e.size()) ? 1 : 0;
      for (int i = 0; i < a.size() && i < e.size(); i++) if (a[i] !== e[i]) n++;
      return n;
   endfunction

   task automatic send_frame(input byte_q_t p, input int drop_at, output int t0);
      int idx;
      int guard;
      idx = 0;
      guard = 0;
      t0 = cyc;
      tx_valid = 1'b1;
      tx_data = p[0];
      tx_last = (p.size() == 1);
      forever begin
         @(negedge eth_clk);
         if (tx_ready) idx++;
         @(posedge eth_clk);
         #1;
         guard++;
         if (idx == p.size() || idx == drop_at) begin
            tx_valid = 1'b0;
            tx_last = 1'b0;
            tx_data = 8'h00;
            break;
         end
         if (guard > 20000) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: accepted %0d of %0d bytes", idx, p.size());
            tx_valid = 1'b0;
            break;
         end
         tx_data = p[idx];
         tx_last = (idx == p.size() - 1);
      end
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      do begin
         @(posedge eth_clk);
         #1;
         guard++;
      end while (busy && guard < 5000);
      tests++;
      if (busy) begin
         fails++;
         $display("FAIL idle_timeout: busy=%b required 0", busy);
      end
   endtask

   task automatic wait_bursts(input int n);
      int guard;
      guard = 0;
      while (burst_cnt < n && guard < 10000) begin
         @(posedge eth_clk);
         #1;
         guard++;
      end
      tests++;
      if (burst_cnt < n) begin
         fails++;
         $display("FAIL burst_timeout: bursts=%0d required %0d", burst_cnt, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge eth_clk);
      @(negedge eth_clk);
      tests++; if (eth_txen !== 1'b0) begin fails++; $display("FAIL reset_txen: got %b required 0", eth_txen); end
      tests++; if (eth_tx !== 2'b00) begin fails++; $display("FAIL reset_tx: got %b required 00", eth_tx); end
      tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b required 0", tx_ready); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
      tests++; if (tx_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b required 0", tx_done); end
      tests++; if (tx_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b required 0", tx_err); end
      @(posedge eth_clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge eth_clk);
      @(negedge eth_clk);
      tests++; if (busy !== 1'b0 || eth_txen !== 1'b0) begin fails++; $display("FAIL post_reset_idle: busy=%b txen=%b required 0 0", busy, eth_txen); end
   endtask

   task automatic test_nominal();
      byte_q_t p;
      byte_q_t wb;
      dib_q_t  exp;
      int      t0;
      int      b0;
      int      d0;
      int      bad;
      p = {};
      for (int i = 0; i < 60; i++) p.push_back(i[7:0]);
      wait_idle();
      b0 = burst_cnt;
      d0 = done_cnt;
      send_frame(p, -1, t0);
      wait_bursts(b0 + 1);
      tests++; if (lens[b0] !== 288) begin fails++; $display("FAIL nominal_len: got %0d required 288", lens[b0]); end
      tests++; if (starts[b0] !== t0 + 1) begin fails++; $display("FAIL nominal_start: txen rose at %0d required %0d", starts[b0], t0 + 1); end
      bad = 0;
      for (int i = 0; i < 31; i++) if (last_dibs[i] !== 2'b01) bad++;
      if (last_dibs[31] !== 2'b11) bad++;
      tests++; if (bad !== 0) begin fails++; $display("FAIL nominal_preamble: %0d bad dibits required 0", bad); end
      build_exp(p, exp);
      bad = count_diff(last_dibs, exp);
      tests++; if (bad !== 0) begin fails++; $display("FAIL nominal_frame: %0d dibit differences required 0", bad); end
      dibs_to_bytes(last_dibs, wb);
      tests++; if ({wb[71], wb[70], wb[69], wb[68]} !== ~crc_reg(p)) begin fails++; $display("FAIL nominal_fcs: got %h required %h", {wb[71], wb[70], wb[69], wb[68]}, ~crc_reg(p)); end
      wb = wb[8:$];
      tests++; if (crc_reg(wb) !== 32'hDEBB_20E3) begin fails++; $display("FAIL nominal_residue: got %h required debb20e3", crc_reg(wb)); end
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL nominal_done: got %0d pulses required 1", done_cnt - d0); end
   endtask

   task automatic test_short();
      byte_q_t p;
      byte_q_t pl;
      byte_q_t wb;
      dib_q_t  exp;
      int      t0;
      int      b0;
      int      bad;
      p = {};
      for (int i = 0; i < 14; i++) p.push_back(8'hA0 + i[7:0]);
      pl = p;
      for (int i = 0; i < 46; i++) pl.push_back(8'h00);
      wait_idle();
      b0 = burst_cnt;
      send_frame(p, -1, t0);
      wait_bursts(b0 + 1);
      tests++; if (lens[b0] !== 288) begin fails++; $display("FAIL short_len: got %0d required 288", lens[b0]); end
      dibs_to_bytes(last_dibs, wb);
      bad = 0;
      for (int i = 22; i < 68 && i < wb.size(); i++) if (wb[i] !== 8'h00) bad++;
      tests++; if (bad !== 0) begin fails++; $display("FAIL short_pad: %0d nonzero pad bytes required 0", bad); end
      tests++; if ({wb[71], wb[70], wb[69], wb[68]} !== ~crc_reg(pl)) begin fails++; $display("FAIL short_fcs: got %h required %h", {wb[71], wb[70], wb[69], wb[68]}, ~crc_reg(pl)); end
      build_exp(p, exp);
      bad = count_diff(last_dibs, exp);
      tests++; if (bad !== 0) begin fails++; $display("FAIL short_frame: %0d dibit differences required 0", bad); end
   endtask

   task automatic test_back_to_back();
      byte_q_t p1;
      byte_q_t p2;
      dib_q_t  exp;
      int      t0;
      int      b0;
      int      d0;
      int      bad;
      p1 = {};
      p2 = {};
      for (int i = 0; i < 64; i++) begin
         p1.push_back(8'(i * 3));
         p2.push_back(~i[7:0]);
      end
      wait_idle();
      b0 = burst_cnt;
      d0 = done_cnt;
      send_frame(p1, -1, t0);
      send_frame(p2, -1, t0);
      wait_bursts(b0 + 2);
      tests++; if (lens[b0] !== 304) begin fails++; $display("FAIL b2b_len1: got %0d required 304", lens[b0]); end
      tests++; if (lens[b0+1] !== 304) begin fails++; $display("FAIL b2b_len2: got %0d required 304", lens[b0+1]); end
      tests++; if (starts[b0+1] - ends[b0] - 1 !== 49) begin fails++; $display("FAIL b2b_gap: got %0d required 49", starts[b0+1] - ends[b0] - 1); end
      tests++; if (done_cnt - d0 !== 2) begin fails++; $display("FAIL b2b_done: got %0d pulses required 2", done_cnt - d0); end
      build_exp(p2, exp);
      bad = count_diff(last_dibs, exp);
      tests++; if (bad !== 0) begin fails++; $display("FAIL b2b_frame2: %0d dibit differences required 0", bad); end
   endtask

   task automatic test_underrun();
      byte_q_t p1;
      byte_q_t p2;
      dib_q_t  exp;
      int      t0;
      int      b0;
      int      d0;
      int      e0;
      int      guard;
      int      bad;
      p1 = {};
      p2 = {};
      for (int i = 0; i < 20; i++) begin
         p1.push_back(8'h30 + i[7:0]);
         p2.push_back(8'hC0 ^ i[7:0]);
      end
      wait_idle();
      b0 = burst_cnt;
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(p1, 10, t0);
      guard = 0;
      while (err_cnt == e0 && guard < 50) begin
         @(posedge eth_clk);
         #1;
         guard++;
      end
      send_frame(p2, -1, t0);
      wait_bursts(b0 + 2);
      tests++; if (lens[b0] !== 72) begin fails++; $display("FAIL underrun_len: got %0d required 72", lens[b0]); end
      tests++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL underrun_err: got %0d pulses required 1", err_cnt - e0); end
      tests++; if (err_cyc !== ends[b0] + 1) begin fails++; $display("FAIL underrun_err_time: got cycle %0d required %0d", err_cyc, ends[b0] + 1); end
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL underrun_done: got %0d pulses required 1", done_cnt - d0); end
      tests++; if (starts[b0+1] - ends[b0] - 1 !== 49) begin fails++; $display("FAIL underrun_gap: got %0d required 49", starts[b0+1] - ends[b0] - 1); end
      build_exp(p2, exp);
      bad = count_diff(last_dibs, exp);
      tests++; if (bad !== 0) begin fails++; $display("FAIL underrun_next_frame: %0d dibit differences required 0", bad); end
   endtask

   task automatic test_reset_mid_fcs();
      byte_q_t p;
      dib_q_t  exp;
      int      t0;
      int      b0;
      int      d0;
      int      guard;
      int      bad;
      p = {};
      for (int i = 0; i < 60; i++) p.push_back(8'h5A ^ i[7:0]);
      wait_idle();
      b0 = burst_cnt;
      d0 = done_cnt;
      send_frame(p, -1, t0);
      guard = 0;
      while (cur_len < 280 && guard < 2000) begin
         @(posedge eth_clk);
         #1;
         guard++;
      end
      rst = 1'b1;
      @(posedge eth_clk);
      #1;
      rst = 1'b0;
      @(negedge eth_clk);
      tests++; if (eth_txen !== 1'b0) begin fails++; $display("FAIL rstfcs_txen: got %b required 0", eth_txen); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstfcs_busy: got %b required 0", busy); end
      @(posedge eth_clk);
      #1;
      p = {};
      for (int i = 0; i < 20; i++) p.push_back(8'h11 * i[7:0]);
      send_frame(p, -1, t0);
      wait_bursts(b0 + 2);
      tests++; if (lens[b0] !== 281) begin fails++; $display("FAIL rstfcs_abort_len: got %0d required 281", lens[b0]); end
      tests++; if (lens[b0+1] !== 288) begin fails++; $display("FAIL rstfcs_next_len: got %0d required 288", lens[b0+1]); end
      build_exp(p, exp);
      bad = count_diff(last_dibs, exp);
      tests++; if (bad !== 0) begin fails++; $display("FAIL rstfcs_next_frame: %0d dibit differences required 0", bad); end
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL rstfcs_done: got %0d pulses required 1", done_cnt - d0); end
   endtask

   task automatic test_backpressure();
      byte_q_t p;
      dib_q_t  exp;
      int      t0;
      int      b0;
      int      d0;
      int      bad;
      int      n;
      d0 = done_cnt;
      for (int f = 0; f < 12; f++) begin
         n = $urandom_range(1, 300);
         p = {};
         for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
         wait_idle();
         repeat ($urandom_range(0, 4)) begin
            @(posedge eth_clk);
            #1;
         end
         b0 = burst_cnt;
         send_frame(p, -1, t0);
         wait_bursts(b0 + 1);
         build_exp(p, exp);
         bad = count_diff(last_dibs, exp);
         tests++; if (bad !== 0) begin fails++; $display("FAIL bp_frame%0d: %0d dibit differences (len %0d) required 0", f, bad, n); end
      end
      tests++; if (done_cnt - d0 !== 12) begin fails++; $display("FAIL bp_done: got %0d pulses required 12", done_cnt - d0); end
      tests++; if (ready_bad !== 0) begin fails++; $display("FAIL ready_slot: tx_ready outside slot 3 %0d times required 0", ready_bad); end
      tests++; if (idle_bad !== 0) begin fails++; $display("FAIL idle_output: nonzero eth_tx with txen low %0d times required 0", idle_bad); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_short();
      test_back_to_back();
      test_underrun();
      test_reset_mid_fcs();
      test_backpressure();
      wait_idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
